// File: rtl/sram_pkg.sv
// Shared types and default geometry for the initialised two-port SRAM array.
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 19;
    localparam int DEF_DEPTH = 512;
    localparam int DEF_NWAYS = 4;

endpackage

// File: rtl/bank_ram_2p.sv
// Single way: one write port, one synchronous read port; a same-address
// read and write in one cycle returns the old word.
module bank_ram_2p #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sram_array_2p_init.sv
// NWAYS-bank SRAM array that clears itself after reset, with held read data.
// Define SRAM_ARRAY_BYPASS_EN to forward same-set write data to a same-cycle read.
module sram_array_2p_init
    import sram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NWAYS = DEF_NWAYS,
    localparam int AW   = $clog2(DEPTH),
    localparam int DW   = NWAYS * WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_r_valid,
    output logic             io_r_ready,
    input  logic [AW-1:0]    io_r_addr,
    output logic             io_r_resp_valid,
    output logic [DW-1:0]    io_r_data,
    input  logic             io_w_en,
    output logic             io_w_ready,
    input  logic [AW-1:0]    io_w_addr,
    input  logic [DW-1:0]    io_w_data,
    input  logic [NWAYS-1:0] io_w_mask,
    output logic             io_init_done
);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          done;
    logic          resp_valid;
    logic [DW-1:0] bank_q;
    logic [DW-1:0] rd_view;
    logic [DW-1:0] hold;

    logic          in_init;
    logic          rd_fire;
    logic          wr_fire;
    logic [AW-1:0] wr_addr;

    assign in_init = (state == INIT);
    assign rd_fire = io_r_valid & done;
    assign wr_fire = io_w_en & done;
    assign wr_addr = in_init ? cnt : io_w_addr;

    assign io_r_ready      = done;
    assign io_w_ready      = done;
    assign io_init_done    = done;
    assign io_r_resp_valid = resp_valid;

    // Clear sweep: one set per cycle, RUN begins after the last set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        done  <= 1'b1;
                    end
                end
                RUN:     done  <= 1'b1;
                default: state <= INIT;
            endcase
        end
    end

    for (genvar i = 0; i < NWAYS; i++) begin : g_way
        logic             we;
        logic [WIDTH-1:0] wd;

        assign we = in_init | (wr_fire & io_w_mask[i]);
        assign wd = in_init ? '0 : io_w_data[i*WIDTH +: WIDTH];

        bank_ram_2p #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_bank (
            .clock (clock),
            .we    (we),
            .waddr (wr_addr),
            .wdata (wd),
            .re    (rd_fire),
            .raddr (io_r_addr),
            .rdata (bank_q[i*WIDTH +: WIDTH])
        );
    end

`ifdef SRAM_ARRAY_BYPASS_EN
    logic             byp_hit;
    logic [NWAYS-1:0] byp_mask;
    logic [DW-1:0]    byp_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byp_hit  <= 1'b0;
            byp_mask <= '0;
            byp_data <= '0;
        end else begin
            byp_hit  <= rd_fire & wr_fire & (io_r_addr == io_w_addr);
            byp_mask <= io_w_mask;
            byp_data <= io_w_data;
        end
    end

    always_comb begin
        rd_view = bank_q;
        for (int i = 0; i < NWAYS; i++) begin
            if (byp_hit && byp_mask[i])
                rd_view[i*WIDTH +: WIDTH] = byp_data[i*WIDTH +: WIDTH];
        end
    end
`else
    assign rd_view = bank_q;
`endif

    // Between responses the output shows the last response, not the raw banks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            hold       <= '0;
        end else begin
            resp_valid <= rd_fire;
            if (resp_valid) hold <= rd_view;
        end
    end

    assign io_r_data = resp_valid ? rd_view : hold;

endmodule
